// File: rtl/tx_framer_if.sv
// rtl/tx_framer_if.sv - payload-in / byte-out bundle for the Ethernet TX framer
//
// Purpose: groups the byte-advance strobe, the payload stream and the
// transmit byte stream with its status flags.
// Signals:
//   adv        byte-advance enable (one slot per asserted cycle)
//   in_data    payload byte (DA through end of payload)
//   in_valid   payload byte valid / new-frame request in IDLE
//   in_last    final payload byte
//   in_ready   payload byte consumed this cycle when in_valid=1
//   tx_data    byte to the RGMII transmitter
//   tx_enable  tx_data belongs to a frame
//   tx_err     transmit error marker
//   busy       framer is not idle
//   frame_done one-cycle pulse with the final FCS byte
//   underrun   sticky payload-underrun flag
// Modports: master drives the payload side, slave is the framer.
interface tx_framer_if;
  logic       adv;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_err;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  modport master (
    output adv, in_data, in_valid, in_last,
    input  in_ready, tx_data, tx_enable, tx_err, busy, frame_done, underrun
  );

  modport slave (
    input  adv, in_data, in_valid, in_last,
    output in_ready, tx_data, tx_enable, tx_err, busy, frame_done, underrun
  );
endinterface

// File: rtl/tx_framer.sv
// rtl/tx_framer.sv - Ethernet TX framer: preamble, SFD, payload, pad, CRC-32 FCS, IFG
//
// Purpose: wraps a raw payload stream into a wire frame for an RGMII
// transmitter. All state moves only on cycles with adv=1 so the same logic
// serves 1000/100/10 Mb/s by strobing adv every 1/10/100 cycles.
// Ports:
//   clk125MHz  sole clock, rising edge
//   rst        asynchronous active-high reset
//   bus        tx_framer_if.slave (payload in, wire bytes and status out)
// Parameters:
//   MIN_LEN    minimum payload length; shorter payloads are zero-padded (0 = no pad)
//   IFG_BYTES  inter-frame gap in advance slots
module tx_framer #(
  parameter int MIN_LEN   = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic        clk125MHz,
  input  logic        rst,
  tx_framer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    PAD,
    FCS,
    IFG
  } state_t;

  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [15:0] PREAMBLE_LAST = 16'd6;
  localparam logic [11:0] MIN_LEN_W     = 12'(MIN_LEN);
  localparam logic [15:0] IFG_LAST      = 16'(IFG_BYTES - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_tx_data, w_tx_data_nxt;
  logic        r_tx_enable, w_tx_enable_nxt;
  logic        r_tx_err, w_tx_err_nxt;
  logic        r_frame_done, w_frame_done_nxt;
  logic        r_underrun, w_underrun_nxt;
  logic [10:0] r_len, w_len_nxt;
  logic [15:0] r_slot, w_slot_nxt;
  logic [31:0] r_crc, w_crc_nxt;

  logic [11:0] w_len_inc;
  logic [10:0] w_len_sat;
  logic [31:0] w_fcs;

  // Byte-wise reflected CRC-32 update.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // r_len counts payload plus pad bytes; it sticks at 2047 on jumbo payloads.
  assign w_len_inc = {1'b0, r_len} + 12'd1;
  assign w_len_sat = (r_len == 11'h7FF) ? r_len : w_len_inc[10:0];
  assign w_fcs     = ~r_crc;

  assign bus.in_ready   = (r_state == PAYLOAD) && bus.adv && !rst;
  assign bus.busy       = (r_state != IDLE);
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_enable  = r_tx_enable;
  assign bus.tx_err     = r_tx_err;
  assign bus.frame_done = r_frame_done;
  assign bus.underrun   = r_underrun;

  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_tx_data    <= 8'h00;
      r_tx_enable  <= 1'b0;
      r_tx_err     <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_len        <= 11'd0;
      r_slot       <= 16'd0;
      r_crc        <= CRC_INIT;
    end else begin
      r_state      <= w_state_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_enable  <= w_tx_enable_nxt;
      r_tx_err     <= w_tx_err_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_underrun   <= w_underrun_nxt;
      r_len        <= w_len_nxt;
      r_slot       <= w_slot_nxt;
      r_crc        <= w_crc_nxt;
    end
  end

  // Each branch registers the byte for the current advance slot, so the
  // IDLE->PREAMBLE edge already puts the first 0x55 on the wire.
  always_comb begin
    w_state_nxt      = r_state;
    w_tx_data_nxt    = r_tx_data;
    w_tx_enable_nxt  = r_tx_enable;
    w_tx_err_nxt     = r_tx_err;
    w_frame_done_nxt = 1'b0;
    w_underrun_nxt   = r_underrun;
    w_len_nxt        = r_len;
    w_slot_nxt       = r_slot;
    w_crc_nxt        = r_crc;

    if (bus.adv) begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            w_state_nxt     = PREAMBLE;
            w_tx_data_nxt   = 8'h55;
            w_tx_enable_nxt = 1'b1;
            w_tx_err_nxt    = 1'b0;
            w_slot_nxt      = 16'd1;
            w_len_nxt       = 11'd0;
          end
        end
        PREAMBLE: begin
          w_tx_data_nxt   = 8'h55;
          w_tx_enable_nxt = 1'b1;
          w_tx_err_nxt    = 1'b0;
          w_slot_nxt      = r_slot + 16'd1;
          if (r_slot == PREAMBLE_LAST) begin
            w_state_nxt = SFD;
          end
        end
        SFD: begin
          w_tx_data_nxt   = 8'hD5;
          w_tx_enable_nxt = 1'b1;
          w_tx_err_nxt    = 1'b0;
          w_crc_nxt       = CRC_INIT;
          w_len_nxt       = 11'd0;
          w_slot_nxt      = 16'd0;
          w_state_nxt     = PAYLOAD;
        end
        PAYLOAD: begin
          if (bus.in_valid) begin
            w_tx_data_nxt   = bus.in_data;
            w_tx_enable_nxt = 1'b1;
            w_tx_err_nxt    = 1'b0;
            w_crc_nxt       = crc32_byte(r_crc, bus.in_data);
            w_len_nxt       = w_len_sat;
            if (bus.in_last) begin
              w_slot_nxt  = 16'd0;
              w_state_nxt = (w_len_inc < MIN_LEN_W) ? PAD : FCS;
            end
          end else begin
            // Source starved: poison the frame and abandon it.
            w_tx_data_nxt   = 8'h00;
            w_tx_enable_nxt = 1'b1;
            w_tx_err_nxt    = 1'b1;
            w_underrun_nxt  = 1'b1;
            w_slot_nxt      = 16'd0;
            w_state_nxt     = IFG;
          end
        end
        PAD: begin
          w_tx_data_nxt   = 8'h00;
          w_tx_enable_nxt = 1'b1;
          w_tx_err_nxt    = 1'b0;
          w_crc_nxt       = crc32_byte(r_crc, 8'h00);
          w_len_nxt       = w_len_sat;
          if (w_len_inc >= MIN_LEN_W) begin
            w_slot_nxt  = 16'd0;
            w_state_nxt = FCS;
          end
        end
        FCS: begin
          case (r_slot[1:0])
            2'd0:    w_tx_data_nxt = w_fcs[7:0];
            2'd1:    w_tx_data_nxt = w_fcs[15:8];
            2'd2:    w_tx_data_nxt = w_fcs[23:16];
            default: w_tx_data_nxt = w_fcs[31:24];
          endcase
          w_tx_enable_nxt = 1'b1;
          w_tx_err_nxt    = 1'b0;
          w_slot_nxt      = r_slot + 16'd1;
          if (r_slot[1:0] == 2'd3) begin
            w_frame_done_nxt = 1'b1;
            w_slot_nxt       = 16'd0;
            w_state_nxt      = IFG;
          end
        end
        IFG: begin
          w_tx_data_nxt   = 8'h00;
          w_tx_enable_nxt = 1'b0;
          w_tx_err_nxt    = 1'b0;
          w_slot_nxt      = r_slot + 16'd1;
          if (r_slot == IFG_LAST) begin
            w_slot_nxt  = 16'd0;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule
